// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter:
// FSM state encoding and requester port ids.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t RESP = 2'd2;
  localparam state_t ACK  = 2'd3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin pick: a lone requester wins,
// on a tie the port not granted last time wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  assign grant = (req == 2'b11) ? ~last : req[PORT_EXT];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and an external loader/debug port
// onto one single-port byte memory, one transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0]  cpu_wd,
  output logic              cpu_ack,
  output logic [WIDTH-1:0]  cpu_rd,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [AWIDTH-1:0] ext_adr,
  input  logic [WIDTH-1:0]  ext_wd,
  output logic              ext_ack,
  output logic [WIDTH-1:0]  ext_rd,
  output logic [AWIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0]  mem_wd,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [WIDTH-1:0]  mem_rd
);

  state_t state;
  logic   owner;
  logic   owner_we;
  logic   last;
  logic   grant;
  logic   busy;
  logic   done;

  rr_pick2 u_pick (
    .req   ({ext_req, cpu_req}),
    .last  (last),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= PORT_CPU;
      owner_we <= 1'b0;
      last     <= PORT_EXT;
      cpu_rd   <= '0;
      ext_rd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || ext_req) begin
            owner    <= grant;
            owner_we <= (grant == PORT_EXT) ? ext_we : cpu_we;
            last     <= grant;
            state    <= BUSY;
          end
        end
        BUSY: state <= owner_we ? IDLE : RESP;
        RESP: begin
          if (owner == PORT_EXT) ext_rd <= mem_rd;
          else                   cpu_rd <= mem_rd;
          state <= ACK;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gate with rst so a reset landing mid-transaction drops ack/strobes at once.
  assign busy = !rst && (state == BUSY);
  assign done = !rst && ((state == BUSY && owner_we) || state == ACK);

  assign cpu_ack = done && (owner == PORT_CPU);
  assign ext_ack = done && (owner == PORT_EXT);

  assign mem_we  = busy && owner_we;
  assign mem_re  = busy && !owner_we;
  assign mem_adr = !busy ? '0 : (owner == PORT_EXT) ? ext_adr : cpu_adr;
  assign mem_wd  = !busy ? '0 : (owner == PORT_EXT) ? ext_wd  : cpu_wd;

  assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, ext_req, ext_we;
  logic [7:0] cpu_adr, cpu_wd, ext_adr, ext_wd;
  logic       cpu_ack, cpu_stall, ext_ack;
  logic [7:0] cpu_rd, ext_rd;
  logic [7:0] mem_adr, mem_wd, mem_rd;
  logic       mem_we, mem_re;

  logic [7:0] mem_arr [256];
  logic [7:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WIDTH(8), .AWIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_ack(cpu_ack), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_adr(ext_adr), .ext_wd(ext_wd),
    .ext_ack(ext_ack), .ext_rd(ext_rd),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory model: read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rd <= mem_arr[mem_adr];
    if (mem_we) mem_arr[mem_adr] = mem_wd;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wd = 0;
    ext_req = 0; ext_we = 0; ext_adr = 0; ext_wd = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wd = 0;
    ext_req = 0; ext_we = 0; ext_adr = 0; ext_wd = 0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({cpu_ack, ext_ack} !== 2'b00) begin errors++; $display("FAIL rst_acks got %b exp 00", {cpu_ack, ext_ack}); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b exp 00", {mem_we, mem_re}); end
    checks++; if (cpu_rd !== 8'h00) begin errors++; $display("FAIL rst_cpu_rd got %h exp 00", cpu_rd); end
    checks++; if (ext_rd !== 8'h00) begin errors++; $display("FAIL rst_ext_rd got %h exp 00", ext_rd); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({cpu_ack, ext_ack, mem_we, mem_re} !== 4'b0) begin errors++; $display("FAIL post_rst_out got %b exp 0000", {cpu_ack, ext_ack, mem_we, mem_re}); end
    checks++; if ({mem_adr, mem_wd} !== 16'h0) begin errors++; $display("FAIL idle_mem_bus got %h exp 0000", {mem_adr, mem_wd}); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b exp 0", cpu_stall); end
  endtask

  task automatic test_cpu_write();
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_adr = 8'h10; cpu_wd = 8'hA5;
    @(negedge clk);
    checks++; if ({cpu_ack, mem_we} !== 2'b00) begin errors++; $display("FAIL wr_c0 got %b exp 00", {cpu_ack, mem_we}); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL wr_c0_stall got %b exp 1", cpu_stall); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we got %b exp 1", mem_we); end
    checks++; if (mem_adr !== 8'h10) begin errors++; $display("FAIL wr_mem_adr got %h exp 10", mem_adr); end
    checks++; if (mem_wd !== 8'hA5) begin errors++; $display("FAIL wr_mem_wd got %h exp a5", mem_wd); end
    checks++; if ({cpu_ack, ext_ack} !== 2'b10) begin errors++; $display("FAIL wr_ack got %b exp 10", {cpu_ack, ext_ack}); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL wr_stall got %b exp 0", cpu_stall); end
    @(posedge clk); #1 cpu_req = 0;
    @(negedge clk);
    checks++; if ({cpu_ack, mem_we} !== 2'b00) begin errors++; $display("FAIL wr_after got %b exp 00", {cpu_ack, mem_we}); end
  endtask

  task automatic test_cpu_read();
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_adr = 8'h10; cpu_wd = 8'h00;
    @(negedge clk);
    checks++; if ({cpu_ack, mem_re} !== 2'b00) begin errors++; $display("FAIL rd_c0 got %b exp 00", {cpu_ack, mem_re}); end
    @(negedge clk);
    checks++; if ({mem_re, mem_we} !== 2'b10) begin errors++; $display("FAIL rd_c1_strobe got %b exp 10", {mem_re, mem_we}); end
    checks++; if (mem_adr !== 8'h10) begin errors++; $display("FAIL rd_c1_adr got %h exp 10", mem_adr); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_c1_ack got %b exp 0", cpu_ack); end
    @(negedge clk);
    checks++; if ({cpu_ack, mem_re} !== 2'b00) begin errors++; $display("FAIL rd_c2 got %b exp 00", {cpu_ack, mem_re}); end
    @(negedge clk);
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_c3_ack got %b exp 1", cpu_ack); end
    checks++; if (cpu_rd !== 8'hA5) begin errors++; $display("FAIL rd_cpu_rd got %h exp a5", cpu_rd); end
    checks++; if (ext_rd !== 8'h00) begin errors++; $display("FAIL rd_ext_rd got %h exp 00", ext_rd); end
    @(posedge clk); #1 cpu_req = 0;
    @(negedge clk);
    checks++; if (cpu_rd !== 8'hA5) begin errors++; $display("FAIL rd_hold got %h exp a5", cpu_rd); end
  endtask

  task automatic test_alternate();
    int k = 0;
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_adr = 8'h01; cpu_wd = 8'h11;
    ext_req = 1; ext_we = 1; ext_adr = 8'h02; ext_wd = 8'h22;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      checks++; if (cpu_ack && ext_ack) begin errors++; $display("FAIL alt_two_acks cyc %0d got 11 exp one", cyc); end
      if (cpu_ack || ext_ack) begin
        checks++; if (cpu_ack !== (k % 2 == 0)) begin errors++; $display("FAIL alt_owner ack %0d got cpu_ack %b exp %b", k, cpu_ack, (k % 2 == 0)); end
        checks++; if (cyc !== 2 * k + 1) begin errors++; $display("FAIL alt_timing ack %0d got cyc %0d exp %0d", k, cyc, 2 * k + 1); end
        k++;
      end
    end
    checks++; if (k !== 8) begin errors++; $display("FAIL alt_count got %0d exp 8", k); end
    @(posedge clk); #1 cpu_req = 0; ext_req = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_arr[8'h20] = 8'h5C;
    ext_req = 1; ext_we = 0; ext_adr = 8'h20;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL rm_busy_re got %b exp 1", mem_re); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if ({ext_ack, mem_we, mem_re} !== 3'b0) begin errors++; $display("FAIL rm_during got %b exp 000", {ext_ack, mem_we, mem_re}); end
    @(posedge clk); #1 rst = 1'b0; ext_req = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if ({ext_ack, cpu_ack, mem_we, mem_re} !== 4'b0) begin errors++; $display("FAIL rm_after%0d got %b exp 0000", i, {ext_ack, cpu_ack, mem_we, mem_re}); end
      checks++; if (ext_rd !== 8'h00) begin errors++; $display("FAIL rm_ext_rd%0d got %h exp 00", i, ext_rd); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    mem_arr[8'h20] = 8'h5C;
    ext_req = 1; ext_we = 0; ext_adr = 8'h20;
    @(negedge clk);
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_adr = 8'h30; cpu_wd = 8'h3C;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL st_stall c%0d got %b exp 1", c, cpu_stall); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL st_cpu_ack c%0d got %b exp 0", c, cpu_ack); end
      checks++; if (ext_ack !== (c == 3)) begin errors++; $display("FAIL st_ext_ack c%0d got %b exp %b", c, ext_ack, (c == 3)); end
      if (c == 3) begin
        checks++; if (ext_rd !== 8'h5C) begin errors++; $display("FAIL st_ext_rd got %h exp 5c", ext_rd); end
        @(posedge clk); #1 ext_req = 0;
      end
    end
    @(negedge clk);
    checks++; if ({cpu_ack, cpu_stall} !== 2'b10) begin errors++; $display("FAIL st_c5 ack/stall got %b exp 10", {cpu_ack, cpu_stall}); end
    checks++; if ({mem_we, mem_adr} !== {1'b1, 8'h30}) begin errors++; $display("FAIL st_c5_mem got %h exp 130", {mem_we, mem_adr}); end
    checks++; if (cpu_rd !== 8'h00) begin errors++; $display("FAIL st_cpu_rd got %h exp 00", cpu_rd); end
    @(posedge clk); #1 cpu_req = 0;
  endtask

  task automatic test_random();
    bit m_active = 0, m_owner = 0, m_we = 0, m_last = 1;
    logic [7:0] m_adr = 0, m_wd = 0, e_cpu_rd = 0, e_ext_rd = 0, e_adr;
    int m_grant_c = 0, m_ack_at = 0, m_free_at = 0;
    bit cpu_pend = 0, ext_pend = 0, cpu_seen = 0, ext_seen = 0;
    bit e_we, e_re, e_ca, e_ea, both;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
    for (int c = 0; c < 2000; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      if (cpu_seen) begin cpu_pend = 0; cpu_req = 0; end
      if (ext_seen) begin ext_pend = 0; ext_req = 0; end
      if (!cpu_pend && $urandom_range(2) == 0) begin
        cpu_pend = 1; cpu_req = 1; cpu_we = 1'($urandom_range(1));
        cpu_adr = 8'($urandom_range(15)); cpu_wd = 8'($urandom);
      end
      if (!ext_pend && $urandom_range(2) == 0) begin
        ext_pend = 1; ext_req = 1; ext_we = 1'($urandom_range(1));
        ext_adr = 8'($urandom_range(15)); ext_wd = 8'($urandom);
      end
      @(negedge clk);
      e_we = 0; e_re = 0; e_ca = 0; e_ea = 0; e_adr = 0;
      if (m_active && c == m_grant_c + 1) begin
        e_we = m_we; e_re = !m_we; e_adr = m_adr;
      end
      if (m_active && c == m_ack_at) begin
        if (m_owner) e_ea = 1; else e_ca = 1;
        if (m_we) ref_mem[m_adr] = m_wd;
        else if (m_owner) e_ext_rd = ref_mem[m_adr];
        else e_cpu_rd = ref_mem[m_adr];
        m_active = 0; m_free_at = c + 1;
      end
      if (!m_active && c >= m_free_at && (cpu_req || ext_req)) begin
        both = cpu_req && ext_req;
        m_owner = both ? !m_last : ext_req;
        m_we  = m_owner ? ext_we : cpu_we;
        m_adr = m_owner ? ext_adr : cpu_adr;
        m_wd  = m_owner ? ext_wd : cpu_wd;
        m_last = m_owner; m_active = 1; m_grant_c = c;
        m_ack_at = c + (m_we ? 1 : 3);
      end
      checks++; if ({cpu_ack, ext_ack} !== {e_ca, e_ea}) begin errors++; $display("FAIL rnd_acks c%0d got %b exp %b", c, {cpu_ack, ext_ack}, {e_ca, e_ea}); end
      checks++; if ({mem_we, mem_re} !== {e_we, e_re}) begin errors++; $display("FAIL rnd_strobes c%0d got %b exp %b", c, {mem_we, mem_re}, {e_we, e_re}); end
      if (e_we || e_re) begin
        checks++; if (mem_adr !== e_adr) begin errors++; $display("FAIL rnd_adr c%0d got %h exp %h", c, mem_adr, e_adr); end
      end
      if (e_we) begin
        checks++; if (mem_wd !== m_wd) begin errors++; $display("FAIL rnd_wd c%0d got %h exp %h", c, mem_wd, m_wd); end
      end
      checks++; if ({cpu_rd, ext_rd} !== {e_cpu_rd, e_ext_rd}) begin errors++; $display("FAIL rnd_rd c%0d got %h exp %h", c, {cpu_rd, ext_rd}, {e_cpu_rd, e_ext_rd}); end
      checks++; if (cpu_stall !== (cpu_req && !e_ca)) begin errors++; $display("FAIL rnd_stall c%0d got %b exp %b", c, cpu_stall, (cpu_req && !e_ca)); end
      cpu_seen = e_ca; ext_seen = e_ea;
    end
    @(posedge clk); #1 cpu_req = 0; ext_req = 0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wd = 0;
    ext_req = 0; ext_we = 0; ext_adr = 0; ext_wd = 0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_alternate();
    test_reset_mid();
    test_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of memory and both request ports.
REQ-002 Parameter AWIDTH, default 8, byte-address width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_req, cpu_we  input  1 each  CPU controller access request and write qualifier.
REQ-006 cpu_adr  input  AWIDTH; cpu_wd  input  WIDTH  CPU address and write data.
REQ-007 cpu_ack  output  1; cpu_rd  output  WIDTH; cpu_stall  output  1  CPU completion pulse, read data, and hold-off.
REQ-008 ext_req, ext_we  input  1 each; ext_adr  input  AWIDTH; ext_wd  input  WIDTH  external loader/debug port request.
REQ-009 ext_ack  output  1; ext_rd  output  WIDTH  external completion pulse and read data.
REQ-010 mem_adr  output  AWIDTH; mem_wd  output  WIDTH; mem_we, mem_re  output  1 each  single-port byte memory drive.
REQ-011 mem_rd  input  WIDTH  memory read data, valid exactly one cycle after mem_re.

Function
REQ-012 FSM states SHALL be IDLE, BUSY, RESP, ACK; only one requester owns memory at a time.
REQ-013 IDLE: if any req high, SHALL pick winner, register owner and owner's we, go to BUSY; otherwise stay IDLE.
REQ-014 Arbitration SHALL be round-robin over two ports: sole requester wins; on tie the port not granted last wins.
REQ-015 "Last granted" register SHALL update only on the IDLE->BUSY transition.
REQ-016 BUSY: mem_adr/mem_wd SHALL mirror the owner's adr/wd; mem_we = owner write, mem_re = owner read.
REQ-017 Write: owner's ack SHALL pulse in the BUSY cycle; next state IDLE (write latency 1 cycle after request sampled).
REQ-018 Read: BUSY->RESP; in RESP owner's rd register SHALL capture mem_rd; RESP->ACK.
REQ-019 ACK: owner's ack SHALL pulse for one cycle with rd already holding captured data; next state IDLE (read latency 3 cycles after request sampled).
REQ-020 cpu_rd/ext_rd SHALL hold last captured value until that port's next read completes; a port's rd SHALL never change on the other port's read.
REQ-021 Requesters SHALL hold req, we, adr, wd stable from assertion through ack cycle; arbiter samples adr/wd in BUSY only.
REQ-022 Req still high in the cycle after ack SHALL be treated as a new transaction (one IDLE cycle between transactions).
REQ-023 Req dropped before grant SHALL be ignored; req dropped after grant SHALL not abort the in-flight transaction.
REQ-024 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational).
REQ-025 In IDLE, RESP and ACK, mem_we and mem_re SHALL be 0; mem_adr/mem_wd SHALL be 0 in IDLE.
REQ-026 At most one of cpu_ack, ext_ack SHALL be high in any cycle; at most one of mem_we, mem_re.

Reset
REQ-027 rst SHALL force state IDLE, owner CPU, last-granted EXT (CPU wins first tie), cpu_rd = ext_rd = 0.
REQ-028 All acks, mem_we, mem_re SHALL be 0 during and the cycle after rst; rst mid-transaction SHALL abandon it with no ack and no further memory strobe.

Structure
REQ-029 Package mem_arb_pkg SHALL hold state encoding (2-bit typedef) and port ID constants PORT_CPU=0, PORT_EXT=1.
REQ-030 Two-input round-robin pick logic SHALL be sub-module rr_pick2 (inputs req[1:0], last; output grant id).
REQ-031 Target RTL size 120-250 lines excluding package.

Verification
REQ-032 CPU write adr 0x10 wd 0xA5, ext idle -> mem_we=1, mem_adr=0x10, mem_wd=0xA5 one cycle after req; cpu_ack same cycle.
REQ-033 CPU read adr 0x10 with mem_rd=0xA5 -> mem_re one cycle after req, cpu_ack 3 cycles after req, cpu_rd=0xA5, ext_rd unchanged.
REQ-034 Both req high continuously from reset, writes -> grants alternate CPU, EXT, CPU, EXT; never two acks same cycle.
REQ-035 EXT read 0x20 in flight, rst asserted in RESP -> no ext_ack, ext_rd=0, state IDLE, no mem strobes next cycle.
REQ-036 CPU req held during EXT read -> cpu_stall=1 for all cycles until its own ack; cpu served immediately after EXT ACK+IDLE.
